stack_sram_ctrl: RTL and testbench

//  - LIFO (stack) sequencer for the 1024x8 asynchronous SRAM macro, which has a shared tri-state data bus,
//    a read/write select (row_sl) and a chip select (chip_sl).
//  - Turns single-cycle push/pop/swap requests into timed SRAM access sequences.
//  - Owns the stack pointer, the full/empty flags and the bus turnaround. Sits between the stack user logic and the SRAM.

---
 rtl/stack_sram_pkg.sv | 37 +++
 rtl/stack_sram_ptr.sv | 48 ++++
 rtl/stack_sram_ctrl.sv | 152 +++++++++++++++
 tb/tb_stack_sram_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_sram_pkg.sv
// Shared definitions for the stack SRAM sequencer.
//   - Default data/address widths of the 1024x8 asynchronous SRAM macro.
//   - FSM state encoding, 3 bits, ST_IDLE..ST_RD_CAPTURE.
//   - Operation encoding and the accept-cycle request decoder.
package stack_sram_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_SETUP   = 3'd1;
  localparam logic [2:0] ST_WR_STROBE  = 3'd2;
  localparam logic [2:0] ST_WR_HOLD    = 3'd3;
  localparam logic [2:0] ST_RD_SETUP   = 3'd4;
  localparam logic [2:0] ST_RD_CAPTURE = 3'd5;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_SWAP  = 2'd3
  } op_e;

  // Push into an empty stack with pop also asserted has nothing to swap
  // out, so it degrades to a plain write.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    op_e op;
    op = OP_NONE;
    if (push && !pop && !full)      op = OP_WRITE;
    else if (pop && !push && !empty) op = OP_READ;
    else if (push && pop && !empty)  op = OP_SWAP;
    else if (push && pop && empty)   op = OP_WRITE;
    return op;
  endfunction

endpackage

// File: rtl/stack_sram_ptr.sv
// Stack pointer and occupancy counter.
//   clk, rst : clock, synchronous active-high reset
//   inc, dec : advance / retreat the pointer by one entry
//   sp       : next free slot (top of stack is sp-1), wraps modulo DEPTH
//   count    : number of entries, one bit wider than sp
//   full     : registered count==DEPTH
//   empty    : registered count==0
module stack_sram_ptr #(
  parameter int AW    = 10,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] sp,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (inc && !dec)      count_nxt = count + (AW+1)'(1);
    else if (dec && !inc) count_nxt = count - (AW+1)'(1);
  end

  // Flags are computed from the next count so they land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (inc && !dec)      sp <= sp + AW'(1);
      else if (dec && !inc) sp <= sp - AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/stack_sram_ctrl.sv
// LIFO sequencer for a 1024x8 asynchronous SRAM with a shared tri-state bus.
// Optional feature macro: STACK_SRAM_ERR_EN (adds sticky err_ovf / err_udf).
//   clk, rst          : clock, synchronous active-high reset
//   push, pop, din    : single-cycle requests, sampled only while busy==0
//   dout, dout_valid  : popped/swapped-out word and its one-cycle strobe
//   busy, full, empty, count : sequencer and occupancy status
//   sram_data         : bidirectional bus, driven only in the WR_* states
//   sram_addr, sram_row_sl (1=write), sram_chip_sl : SRAM control
//   dbg_state         : current FSM state
// Handshake: a request is taken on a rising edge where busy==0 and the
// decode yields an operation; busy then stays high until the sequence ends.
// Dropped requests (push when full, pop when empty) leave busy low.
module stack_sram_ctrl
  import stack_sram_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  inout  wire  [DW-1:0] sram_data,
  output logic [AW-1:0] sram_addr,
  output logic          sram_row_sl,
  output logic          sram_chip_sl,
`ifdef STACK_SRAM_ERR_EN
  output logic          err_ovf,
  output logic          err_udf,
`endif
  output logic [2:0]    dbg_state
);

  logic [2:0]    state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          swap_q;
  logic [AW-1:0] sp;
  logic          wr_drive;
  logic          ptr_inc;
  logic          ptr_dec;
  op_e           op;

  assign op        = decode_op(push, pop, full, empty);
  assign busy      = (state != ST_IDLE);
  assign sram_addr = addr_q;
  assign dbg_state = state;

  // Bus control is a pure decode of state, so a reset that returns the FSM
  // to IDLE releases the bus and deselects the SRAM on the same edge.
  always_comb begin
    sram_row_sl  = 1'b0;
    sram_chip_sl = 1'b0;
    wr_drive     = 1'b0;
    case (state)
      ST_WR_SETUP:   begin sram_row_sl = 1'b1; wr_drive = 1'b1; end
      ST_WR_STROBE:  begin sram_row_sl = 1'b1; wr_drive = 1'b1; sram_chip_sl = 1'b1; end
      ST_WR_HOLD:    begin sram_row_sl = 1'b1; wr_drive = 1'b1; end
      ST_RD_SETUP:   sram_chip_sl = 1'b1;
      ST_RD_CAPTURE: sram_chip_sl = 1'b1;
      default:       ;
    endcase
  end

  for (genvar i = 0; i < DW; i++) begin : g_drv
    bufif1 u_drv (sram_data[i], wdata_q[i], wr_drive);
  end

  // A swap reuses the read slot for its write, so it never moves sp.
  assign ptr_inc = (state == ST_WR_HOLD)    && !swap_q;
  assign ptr_dec = (state == ST_RD_CAPTURE) && !swap_q;

  stack_sram_ptr #(.AW(AW), .DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ptr_inc),
    .dec   (ptr_dec),
    .sp    (sp),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      swap_q     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          case (op)
            OP_WRITE: begin
              addr_q  <= sp;
              wdata_q <= din;
              swap_q  <= 1'b0;
              state   <= ST_WR_SETUP;
            end
            OP_READ: begin
              addr_q <= sp - AW'(1);
              swap_q <= 1'b0;
              state  <= ST_RD_SETUP;
            end
            OP_SWAP: begin
              addr_q  <= sp - AW'(1);
              wdata_q <= din;
              swap_q  <= 1'b1;
              state   <= ST_RD_SETUP;
            end
            default: ;
          endcase
        end
        ST_WR_SETUP:  state <= ST_WR_STROBE;
        ST_WR_STROBE: state <= ST_WR_HOLD;
        ST_WR_HOLD:   state <= ST_IDLE;
        ST_RD_SETUP:  state <= ST_RD_CAPTURE;
        ST_RD_CAPTURE: begin
          dout       <= sram_data;
          dout_valid <= 1'b1;
          // WR_SETUP deselects the chip, giving the read-to-write turnaround.
          state      <= swap_q ? ST_WR_SETUP : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STACK_SRAM_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (push && !pop && full)  err_ovf <= 1'b1;
      if (pop && !push && empty) err_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_sram_ctrl.sv
// Bench for stack_sram_ctrl with a behavioural asynchronous SRAM model.
module tb_stack_sram_ctrl;
  import stack_sram_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          push = 1'b0;
  logic          pop  = 1'b0;
  logic [DW-1:0] din  = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, busy, full, empty;
  logic [AW:0]   count;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_row_sl, sram_chip_sl;
  logic [2:0]    dbg_state;
`ifdef STACK_SRAM_ERR_EN
  logic          err_ovf, err_udf;
`endif

  stack_sram_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .busy         (busy),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .sram_data    (sram_data),
    .sram_addr    (sram_addr),
    .sram_row_sl  (sram_row_sl),
    .sram_chip_sl (sram_chip_sl),
`ifdef STACK_SRAM_ERR_EN
    .err_ovf      (err_ovf),
    .err_udf      (err_udf),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          sram_rd;
  assign sram_rd   = sram_chip_sl && !sram_row_sl;
  assign sram_data = sram_rd ? mem[sram_addr] : 'z;
  always @(posedge clk)
    if (sram_chip_sl && sram_row_sl) mem[sram_addr] <= sram_data;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops expected words whenever the DUT strobes dout.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (exp_q.size() == 0) chk("unexpected_dout_valid", 32'(dout), 32'hFFFF_FFFF);
      else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  // While the SRAM drives a read, the bus must carry exactly the SRAM word.
  always @(negedge clk) begin
    if (!rst && sram_rd) chk("bus_read_value", 32'(sram_data), 32'(mem[sram_addr]));
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request and returns how many cycles busy stayed high.
  task automatic issue(input logic p, input logic q, input logic [DW-1:0] d,
                       output int busy_cycles);
    @(negedge clk);
    push = p; pop = q; din = d;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  int bc;

  initial begin
    do_reset();

    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_chip_sl", 32'(sram_chip_sl), 0);
    chk("rst_row_sl", 32'(sram_row_sl), 0);
    chk("rst_addr", 32'(sram_addr), 0);

    // first push, phase by phase
    @(negedge clk); push = 1'b1; din = 8'hA5;
    @(negedge clk); push = 1'b0;
    chk("wr_setup_busy", 32'(busy), 1);
    chk("wr_setup_chip", 32'(sram_chip_sl), 0);
    chk("wr_setup_row", 32'(sram_row_sl), 1);
    @(negedge clk);
    chk("wr_strobe_state", 32'(dbg_state), 32'(ST_WR_STROBE));
    chk("wr_strobe_addr", 32'(sram_addr), 0);
    chk("wr_strobe_row", 32'(sram_row_sl), 1);
    chk("wr_strobe_chip", 32'(sram_chip_sl), 1);
    chk("wr_strobe_data", 32'(sram_data), 32'hA5);
    @(negedge clk);
    chk("wr_hold_busy", 32'(busy), 1);
    chk("wr_hold_chip", 32'(sram_chip_sl), 0);
    chk("wr_hold_count", 32'(count), 0);
    @(negedge clk);
    chk("wr_done_busy", 32'(busy), 0);
    chk("wr_done_count", 32'(count), 1);
    chk("wr_done_empty", 32'(empty), 0);

    // LIFO order
    do_reset();
    issue(1, 0, 8'h11, bc); chk("push_busy_cycles", 32'(bc), 3);
    issue(1, 0, 8'h22, bc);
    issue(1, 0, 8'h33, bc);
    chk("lifo_count3", 32'(count), 3);
    exp_q.push_back(8'h33); issue(0, 1, 8'h00, bc); chk("pop_busy_cycles", 32'(bc), 2);
    chk("pop_count", 32'(count), 2);
    exp_q.push_back(8'h22); issue(0, 1, 8'h00, bc);
    exp_q.push_back(8'h11); issue(0, 1, 8'h00, bc);
    chk("lifo_empty", 32'(empty), 1);
    chk("lifo_count0", 32'(count), 0);

    // fill to full
    do_reset();
    for (int i = 0; i < 1024; i++) issue(1, 0, 8'(i), bc);
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), 1024);
    chk("full_empty", 32'(empty), 0);
    issue(1, 0, 8'hCC, bc);
    chk("push_full_busy", 32'(bc), 0);
    chk("push_full_count", 32'(count), 1024);
`ifdef STACK_SRAM_ERR_EN
    chk("err_ovf_set", 32'(err_ovf), 1);
    chk("err_udf_clear", 32'(err_udf), 0);
`endif
    chk("mem0_kept", 32'(mem[0]), 32'h00);
    exp_q.push_back(8'hFF); issue(0, 1, 8'h00, bc);
    chk("unfull_count", 32'(count), 1023);
    chk("unfull_flag", 32'(full), 0);

    // pop on empty, then push&pop on empty
    do_reset();
`ifdef STACK_SRAM_ERR_EN
    chk("err_ovf_rst", 32'(err_ovf), 0);
`endif
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pop_empty_busy", 32'(busy), 0);
      chk("pop_empty_chip", 32'(sram_chip_sl), 0);
      @(negedge clk);
    end
`ifdef STACK_SRAM_ERR_EN
    chk("err_udf_set", 32'(err_udf), 1);
`endif
    issue(1, 1, 8'h5A, bc);
    chk("pp_empty_busy", 32'(bc), 3);
    chk("pp_empty_count", 32'(count), 1);
    exp_q.push_back(8'h5A); issue(0, 1, 8'h00, bc);
    chk("pp_empty_final", 32'(empty), 1);

    // swap
    do_reset();
    issue(1, 0, 8'h10, bc);
    issue(1, 0, 8'h20, bc);
    exp_q.push_back(8'h20); issue(1, 1, 8'h77, bc);
    chk("swap_busy_cycles", 32'(bc), 5);
    chk("swap_count", 32'(count), 2);
    chk("swap_dout_hold", 32'(dout), 32'h20);
    exp_q.push_back(8'h77); issue(0, 1, 8'h00, bc);
    exp_q.push_back(8'h10); issue(0, 1, 8'h00, bc);
    chk("swap_final_empty", 32'(empty), 1);

    // reset in the middle of a write
    @(negedge clk); push = 1'b1; din = 8'h99;
    @(negedge clk); push = 1'b0;
    @(negedge clk);
    chk("abort_in_strobe", 32'(dbg_state), 32'(ST_WR_STROBE));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_chip", 32'(sram_chip_sl), 0);
    chk("abort_row", 32'(sram_row_sl), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_dout", 32'(dout), 0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
